// File: rtl/dmem_be.sv
// ---------------------------------------------------------------------------
// dmem_be -- byte-enabled data memory for the RV32I MEM stage
//
// Serves LB/LH/LW/LBU/LHU/SB/SH/SW through a request/response interface.
// There is no backpressure. A request is accepted on every rising clk edge
// where req_valid=1 and rst=0. A store commits to the array on the edge that
// accepts it. Every accepted request gets exactly one response, and the
// response comes READ_LATENCY cycles after the accept edge. Responses stay
// in order.
//
// Parameters:
//   DEPTH_WORDS   number of 32-bit words (power of two, >= 4)
//   READ_LATENCY  1 or 2; the value 2 adds a registered output stage
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous active-high reset; clears the pipeline and
//                 the outputs, but not the storage
//   req_valid     request strobe
//   req_we        1 = store, 0 = load
//   req_addr      byte address
//   req_size      00 byte, 01 half, 10 word, 11 reserved (error)
//   req_unsigned  load zero-extend (1) or sign-extend (0)
//   req_wdata     right-aligned store data
//   rsp_valid     one-cycle response strobe
//   rsp_rdata     extended load data; 0 for stores and errors
//   rsp_err       out-of-range, reserved-size or misaligned access
//
// Build option:
//   DMEM_MISALIGN_CHK_EN
//     Defined:   a misaligned half or word access is reported as an error.
//     Undefined: the low address bits are forced to alignment instead.
// ---------------------------------------------------------------------------
module dmem_be #(
    parameter int DEPTH_WORDS  = 1024,
    parameter int READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic [AW-1:0] req_idx;
    logic [1:0]    req_lane;      // lowest byte lane touched by the access
    logic          range_err;
    logic          size_err;
    logic          misalign_err;
    logic          req_err;
    logic          wr_en;
    logic          rd_en;
    logic [3:0]    byte_en;
    logic [31:0]   wr_lanes;

    always_comb begin
        req_idx   = req_addr[AW+1:2];
        range_err = |req_addr[31:AW+2];
        size_err  = (req_size == 2'b11);
        // Alignment is enforced by forcing the low address bits. When the
        // misalignment check is built in, misaligned requests are flagged as
        // errors instead, so the forced lane value is never used for them.
        case (req_size)
            2'b00:   req_lane = req_addr[1:0];
            2'b01:   req_lane = {req_addr[1], 1'b0};
            default: req_lane = 2'b00;
        endcase
`ifdef DMEM_MISALIGN_CHK_EN
        misalign_err = ((req_size == 2'b01) && req_addr[0]) ||
                       ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`else
        misalign_err = 1'b0;
`endif
        req_err = range_err | size_err | misalign_err;
    end

    // rst gates the write here so that requests presented during reset
    // never reach the array. The array itself has no reset.
    assign wr_en = req_valid & req_we & ~req_err & ~rst;
    assign rd_en = req_valid & ~req_we & ~req_err;

    // Per-lane enables and data. The store data is replicated across the
    // lanes, so each lane simply picks up its own slice.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign byte_en[gi] = (req_size == 2'b10) |
                                 ((req_size == 2'b01) & (req_lane[1] == 1'(gi / 2))) |
                                 ((req_size == 2'b00) & (req_lane == 2'(gi)));
            assign wr_lanes[gi*8 +: 8] =
                (req_size == 2'b00) ? req_wdata[7:0] :
                (req_size == 2'b01) ? req_wdata[(gi % 2)*8 +: 8] :
                                      req_wdata[gi*8 +: 8];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Storage: one write port with byte lanes and a registered read
    // ------------------------------------------------------------------
    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] rd_word_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[req_idx][i*8 +: 8] <= wr_lanes[i*8 +: 8];
                end
            end
        end
        if (rd_en) begin
            rd_word_q <= mem[req_idx];
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: control that travels alongside the registered read word
    // ------------------------------------------------------------------
    logic       s1_valid_q, s1_valid_d;
    logic       s1_err_q,   s1_err_d;
    logic       s1_load_q,  s1_load_d;
    logic [1:0] s1_size_q,  s1_size_d;
    logic [1:0] s1_lane_q,  s1_lane_d;
    logic       s1_uns_q,   s1_uns_d;

    always_comb begin
        s1_valid_d = req_valid;
        s1_err_d   = req_valid & req_err;
        s1_load_d  = rd_en;
        s1_size_d  = req_size;
        s1_lane_d  = req_lane;
        s1_uns_d   = req_unsigned;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_err_q   <= 1'b0;
            s1_load_q  <= 1'b0;
            s1_size_q  <= 2'b00;
            s1_lane_q  <= 2'b00;
            s1_uns_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_err_q   <= s1_err_d;
            s1_load_q  <= s1_load_d;
            s1_size_q  <= s1_size_d;
            s1_lane_q  <= s1_lane_d;
            s1_uns_q   <= s1_uns_d;
        end
    end

    // Load extraction. The result is forced to zero unless stage 1 holds a
    // good load, which also masks the unreset read word.
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    always_comb begin
        ld_byte = rd_word_q[{s1_lane_q, 3'b000} +: 8];
        ld_half = s1_lane_q[1] ? rd_word_q[31:16] : rd_word_q[15:0];
        case (s1_size_q)
            2'b00:   ld_data = s1_uns_q ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            2'b01:   ld_data = s1_uns_q ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ld_data = rd_word_q;
        endcase
        if (!s1_load_q) begin
            ld_data = 32'd0;
        end
    end

    // ------------------------------------------------------------------
    // Response: taken straight from stage 1, or through one extra register
    // ------------------------------------------------------------------
    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic        rsp_valid_q, rsp_valid_d;
            logic        rsp_err_q,   rsp_err_d;
            logic [31:0] rsp_rdata_q, rsp_rdata_d;

            always_comb begin
                rsp_valid_d = s1_valid_q;
                rsp_err_d   = s1_err_q;
                rsp_rdata_d = ld_data;
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rsp_valid_q <= 1'b0;
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= 32'd0;
                end else begin
                    rsp_valid_q <= rsp_valid_d;
                    rsp_err_q   <= rsp_err_d;
                    rsp_rdata_q <= rsp_rdata_d;
                end
            end

            assign rsp_valid = rsp_valid_q;
            assign rsp_err   = rsp_err_q;
            assign rsp_rdata = rsp_rdata_q;
        end else begin : g_lat1
            assign rsp_valid = s1_valid_q;
            assign rsp_err   = s1_err_q;
            assign rsp_rdata = ld_data;
        end
    endgenerate

endmodule

// File: tb/tb_dmem_be.sv
// ---------------------------------------------------------------------------
// tb_dmem_be -- directed, table-driven bench for dmem_be.
// Two instances share the same stimulus: dut1 has READ_LATENCY=1 and dut2
// has READ_LATENCY=2. Every request is checked on both instances at the
// cycle its latency implies.
// ---------------------------------------------------------------------------
module tb_dmem_be;

`ifdef DMEM_MISALIGN_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_we, req_unsigned;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        v1, e1, v2, e2;
    logic [31:0] d1, d2;

    int n_chk  = 0;
    int n_fail = 0;

    dmem_be #(.DEPTH_WORDS(1024), .READ_LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
        .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata), .rsp_valid(v1), .rsp_rdata(d1), .rsp_err(e1)
    );

    dmem_be #(.DEPTH_WORDS(1024), .READ_LATENCY(2)) dut2 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
        .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata), .rsp_valid(v2), .rsp_rdata(d2), .rsp_err(e2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic we, input logic [31:0] addr, input logic [1:0] size,
                           input logic uns, input logic [31:0] wdata,
                           input logic [31:0] exp_rdata, input logic exp_err);
        vec_t v;
        v.we = we; v.addr = addr; v.size = size; v.uns = uns; v.wdata = wdata;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        vecs.push_back(v);
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic valid, input logic we, input logic [31:0] addr,
                         input logic [1:0] size, input logic uns, input logic [31:0] wdata);
        req_valid = valid; req_we = we; req_addr = addr;
        req_size = size; req_unsigned = uns; req_wdata = wdata;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'd0, 2'b00, 1'b0, 32'd0);
    endtask

    // Issue one request and check the lat-1 response after the accept edge,
    // then the lat-2 response one edge later.
    task automatic run_one(input logic we, input logic [31:0] addr, input logic [1:0] size,
                           input logic uns, input logic [31:0] wdata,
                           input logic [31:0] exp_rdata, input logic exp_err, input int tag);
        @(negedge clk);
        drive(1'b1, we, addr, size, uns, wdata);
        @(posedge clk); #1;
        idle();
        check($sformatf("v%0d lat1 valid", tag), 32'(v1), 32'd1);
        check($sformatf("v%0d lat1 rdata", tag), d1, exp_rdata);
        check($sformatf("v%0d lat1 err", tag), 32'(e1), 32'(exp_err));
        check($sformatf("v%0d lat2 early valid", tag), 32'(v2), 32'd0);
        @(posedge clk); #1;
        check($sformatf("v%0d lat1 extra valid", tag), 32'(v1), 32'd0);
        check($sformatf("v%0d lat2 valid", tag), 32'(v2), 32'd1);
        check($sformatf("v%0d lat2 rdata", tag), d2, exp_rdata);
        check($sformatf("v%0d lat2 err", tag), 32'(e2), 32'(exp_err));
        $display("txn %0d: we=%0d addr=%h size=%0d uns=%0d wdata=%h -> rdata %h/%h err %0d/%0d (exp %h err %0d)",
                 tag, we, addr, size, uns, wdata, d1, d2, e1, e2, exp_rdata, exp_err);
    endtask

    logic        sv1 [6];
    logic        sv2 [6];
    logic [31:0] sd1 [6];
    logic [31:0] sd2 [6];

    initial begin
        // ---------------- vector table ----------------
        //       we    addr           sz     uns   wdata          exp_rdata      exp_err
        add_vec(1'b1, 32'h10,        2'b10, 1'b0, 32'hDEADBEEF, 32'h0,        1'b0);
        add_vec(1'b0, 32'h10,        2'b10, 1'b0, 32'h0,        32'hDEADBEEF, 1'b0);
        add_vec(1'b1, 32'h20,        2'b10, 1'b0, 32'h11223344, 32'h0,        1'b0);
        add_vec(1'b1, 32'h22,        2'b00, 1'b0, 32'h123456AA, 32'h0,        1'b0);
        add_vec(1'b0, 32'h20,        2'b10, 1'b0, 32'h0,        32'h11AA3344, 1'b0);
        add_vec(1'b0, 32'h22,        2'b00, 1'b0, 32'h0,        32'hFFFFFFAA, 1'b0);
        add_vec(1'b0, 32'h22,        2'b00, 1'b1, 32'h0,        32'h000000AA, 1'b0);
        add_vec(1'b1, 32'h30,        2'b10, 1'b0, 32'h55667788, 32'h0,        1'b0);
        add_vec(1'b1, 32'h32,        2'b01, 1'b0, 32'hFFFF8001, 32'h0,        1'b0);
        add_vec(1'b0, 32'h32,        2'b01, 1'b0, 32'h0,        32'hFFFF8001, 1'b0);
        add_vec(1'b0, 32'h32,        2'b01, 1'b1, 32'h0,        32'h00008001, 1'b0);
        add_vec(1'b0, 32'h30,        2'b10, 1'b0, 32'h0,        32'h80017788, 1'b0);
        add_vec(1'b0, 32'h31,        2'b00, 1'b0, 32'h0,        32'h00000077, 1'b0);
        add_vec(1'b0, 32'h30,        2'b01, 1'b0, 32'h0,        32'h00007788, 1'b0);
        add_vec(1'b0, 32'h13,        2'b00, 1'b0, 32'h0,        32'hFFFFFFDE, 1'b0);
        add_vec(1'b0, 32'h10,        2'b00, 1'b1, 32'h0,        32'h000000EF, 1'b0);
        // range: 0x1000 is one past the end and would wrap to word 0
        add_vec(1'b1, 32'h0,         2'b10, 1'b0, 32'hCAFEF00D, 32'h0,        1'b0);
        add_vec(1'b0, 32'h1000,      2'b10, 1'b0, 32'h0,        32'h0,        1'b1);
        add_vec(1'b1, 32'h1000,      2'b10, 1'b0, 32'h12345678, 32'h0,        1'b1);
        add_vec(1'b0, 32'h0,         2'b10, 1'b0, 32'h0,        32'hCAFEF00D, 1'b0);
        add_vec(1'b0, 32'hFFFFFFFC,  2'b10, 1'b0, 32'h0,        32'h0,        1'b1);
        // reserved size: an error, and no write
        add_vec(1'b1, 32'h0,         2'b11, 1'b0, 32'h0,        32'h0,        1'b1);
        add_vec(1'b0, 32'h0,         2'b10, 1'b0, 32'h0,        32'hCAFEF00D, 1'b0);
        add_vec(1'b0, 32'h0,         2'b11, 1'b0, 32'h0,        32'h0,        1'b1);
        // misalignment: either an error, or low bits forced to alignment
        add_vec(1'b1, 32'h40,        2'b10, 1'b0, 32'hA5A55A5A, 32'h0,        1'b0);
        add_vec(1'b0, 32'h41,        2'b10, 1'b0, 32'h0,        CHK ? 32'h0 : 32'hA5A55A5A, CHK);
        add_vec(1'b0, 32'h33,        2'b01, 1'b0, 32'h0,        CHK ? 32'h0 : 32'hFFFF8001, CHK);
        add_vec(1'b1, 32'h31,        2'b01, 1'b0, 32'h00001234, 32'h0,        CHK);
        add_vec(1'b0, 32'h30,        2'b10, 1'b0, 32'h0,        CHK ? 32'h80017788 : 32'h80011234, 1'b0);

        // ---------------- reset state ----------------
        rst = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        check("reset lat1 valid", 32'(v1), 32'd0);
        check("reset lat1 rdata", d1, 32'd0);
        check("reset lat1 err", 32'(e1), 32'd0);
        check("reset lat2 valid", 32'(v2), 32'd0);
        check("reset lat2 rdata", d2, 32'd0);
        check("reset lat2 err", 32'(e2), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // ---------------- table ----------------
        for (int i = 0; i < vecs.size(); i++) begin
            run_one(vecs[i].we, vecs[i].addr, vecs[i].size, vecs[i].uns, vecs[i].wdata,
                    vecs[i].exp_rdata, vecs[i].exp_err, i);
        end

        // ---------------- req_we without req_valid does nothing ----------------
        @(negedge clk);
        drive(1'b0, 1'b1, 32'h10, 2'b10, 1'b0, 32'h0);
        @(posedge clk); #1;
        check("novalid lat1 valid", 32'(v1), 32'd0);
        @(posedge clk); #1;
        check("novalid lat2 valid", 32'(v2), 32'd0);
        run_one(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0, 100);

        // ---------------- back-to-back with read-after-write ----------------
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            case (k)
                0: drive(1'b1, 1'b1, 32'h40, 2'b10, 1'b0, 32'd1);
                1: drive(1'b1, 1'b0, 32'h40, 2'b10, 1'b0, 32'd0);
                2: drive(1'b1, 1'b1, 32'h40, 2'b10, 1'b0, 32'd2);
                3: drive(1'b1, 1'b0, 32'h40, 2'b10, 1'b0, 32'd0);
                default: idle();
            endcase
            @(posedge clk); #1;
            sv1[k] = v1; sd1[k] = d1; sv2[k] = v2; sd2[k] = d2;
            $display("b2b cycle %0d: lat1 v=%0d d=%h  lat2 v=%0d d=%h", k, v1, d1, v2, d2);
        end
        for (int k = 0; k < 4; k++) check($sformatf("b2b lat1 valid %0d", k), 32'(sv1[k]), 32'd1);
        check("b2b lat1 valid 4", 32'(sv1[4]), 32'd0);
        check("b2b lat1 store rdata", sd1[0], 32'd0);
        check("b2b lat1 load1", sd1[1], 32'd1);
        check("b2b lat1 load2", sd1[3], 32'd2);
        check("b2b lat2 valid 0", 32'(sv2[0]), 32'd0);
        for (int k = 1; k < 5; k++) check($sformatf("b2b lat2 valid %0d", k), 32'(sv2[k]), 32'd1);
        check("b2b lat2 valid 5", 32'(sv2[5]), 32'd0);
        check("b2b lat2 load1", sd2[2], 32'd1);
        check("b2b lat2 load2", sd2[4], 32'd2);

        // ---------------- reset mid-flight ----------------
        run_one(1'b1, 32'h50, 2'b10, 1'b0, 32'h00000077, 32'h0, 1'b0, 200);
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h50, 2'b10, 1'b0, 32'h0);
        @(posedge clk); #1;
        idle();
        check("midrst lat1 pre valid", 32'(v1), 32'd1);
        check("midrst lat1 pre rdata", d1, 32'h77);
        rst = 1'b1;
        #1;
        check("midrst lat1 valid", 32'(v1), 32'd0);
        check("midrst lat1 rdata", d1, 32'd0);
        check("midrst lat2 valid", 32'(v2), 32'd0);
        check("midrst lat2 rdata", d2, 32'd0);
        $display("reset asserted mid-flight: lat1 v=%0d d=%h lat2 v=%0d d=%h", v1, d1, v2, d2);
        // A store presented while reset is held must be ignored.
        @(negedge clk);
        drive(1'b1, 1'b1, 32'h50, 2'b10, 1'b0, 32'h99);
        @(posedge clk); #1;
        check("inrst lat1 valid", 32'(v1), 32'd0);
        check("inrst lat2 valid", 32'(v2), 32'd0);
        @(negedge clk);
        idle();
        @(posedge clk); #1;
        check("inrst lat2 valid late", 32'(v2), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_one(1'b0, 32'h50, 2'b10, 1'b0, 32'h0, 32'h00000077, 1'b0, 201);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_be.md
Name: dmem_be

Overview:
- Parametrised successor to the word-only data memory in the RV32I core.
- Adds byte/halfword/word access with byte-lane write enables and load sign/zero extension.
- Adds configurable depth, a registered request/response interface with 1- or 2-cycle read latency, and range/misalignment error reporting.
- Sits between the core's MEM stage and data storage; serves LB/LH/LW/LBU/LHU/SB/SH/SW directly.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words; power of two, minimum 4.
- READ_LATENCY, 1, cycles from request accept to response; legal values are 1 or 2. A value of 2 adds an output register stage.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-high; clears pipeline and outputs only, not storage.
- req_valid  input  1  request present this cycle; always accepted, no backpressure.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_size  input  2  access size: 00 = byte, 01 = half, 10 = word, 11 = reserved.
- req_unsigned  input  1  load only: 1 = zero-extend (LBU/LHU), 0 = sign-extend.
- req_wdata  input  32  store data, right-aligned; low 8/16/32 bits used.
- rsp_valid  output  1  response strobe, one cycle per accepted request.
- rsp_rdata  output  32  extended load data; 0 for stores and errors.
- rsp_err  output  1  error flag for this response.

Behaviour:
- Reset: rsp_valid=0, rsp_rdata=0, rsp_err=0, all pipeline registers cleared. Memory contents are not reset (contents are X after power-up).
- Word index = req_addr[log2(DEPTH_WORDS)+1:2].
- Out of range (req_addr >= DEPTH_WORDS*4):
  - rsp_err=1, rsp_rdata=0.
  - No write occurs.
- Store lane selection, given by size and addr[1:0]:
  - Byte: lane addr[1:0] <= wdata[7:0].
  - Half: lanes {addr[1],0} and {addr[1],1} <= wdata[15:0], little-endian.
  - Word: all lanes <= wdata.
  - Unselected lanes are unchanged.
- Store commit: the write commits on the same clk edge that accepts the request.
- Load extraction:
  - Load reads the same lanes, shifted to bit 0.
  - Bit 7 (byte) or bit 15 (half) is replicated when req_unsigned=0; zeros are filled when req_unsigned=1.
- req_size=11: treated as error. rsp_err=1, no write, rdata 0.
- Latency:
  - rsp_valid pulses exactly READ_LATENCY cycles after the accept edge, for loads and stores alike.
  - Responses stay in order.
  - Back-to-back requests give back-to-back responses, i.e. full throughput.
- Read-after-write: a store accepted at edge N followed by a load to the same word accepted at edge N+1 returns the stored data. No forwarding is needed because the write has already committed.
- Single port: one operation per cycle. req_we with req_valid=0 has no effect.
- Reset mid-operation:
  - In-flight responses are dropped; rsp_valid goes 0 immediately (asynchronous).
  - A store already committed before rst stays in memory.
  - Requests while rst=1 are ignored: no write, no response.

Optional Feature:
- Macro: DMEM_MISALIGN_CHK_EN.
- Defined: misaligned access is an error.
  - Misaligned means half with addr[0]=1, or word with addr[1:0]!=00.
  - Response: rsp_err=1, no write, rdata 0, normal latency.
- Undefined: no misalignment check.
  - Misaligned low address bits are ignored: half uses addr[1] with addr[0] forced to 0; word uses addr[1:0] forced to 00.
  - Access proceeds normally; rsp_err reflects only range and reserved-size errors.

Test Plan:
- Word round trip: SW 0xDEADBEEF @0x10, then LW @0x10 -> rsp_valid after READ_LATENCY, rdata=0xDEADBEEF, err=0.
- Byte lanes: SW 0x11223344 @0x20; SB 0xAA @0x22; LW @0x20 -> 0x11AA3344. LB @0x22 -> 0xFFFFFFAA; LBU @0x22 -> 0x000000AA.
- Halfword: SH 0x8001 @0x32; LH @0x32 -> 0xFFFF8001; LHU @0x32 -> 0x00008001; LW @0x30 -> upper half 0x8001, lower half unchanged.
- Range: LW @DEPTH_WORDS*4 -> err=1, rdata=0. SW to the same address followed by a wrapped-index read (@0x0) shows no change.
- Throughput and RAW: four back-to-back requests SW @0x40=1, LW @0x40, SW @0x40=2, LW @0x40 -> four consecutive rsp_valid cycles, load responses 1 then 2. Repeat with READ_LATENCY=2.
- Reset mid-flight: LW issued, rst asserted before response -> no rsp_valid, outputs 0. A prior committed SW is still readable after rst deasserts. With DMEM_MISALIGN_CHK_EN, LW @0x41 -> err=1.
